// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
//   - Opcode encodings understood by the combinational ALU (0x00..0x0D)
//   - Bit positions of the {V,N,Z,C} flag nibble
//   - Controller state encoding
//   - Helpers for opcode legality and for which opcodes produce meaningful flags
package alu_pkg;

  localparam logic [5:0] OP_PASSA = 6'h00;
  localparam logic [5:0] OP_PASSB = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_XNOR  = 6'h05;
  localparam logic [5:0] OP_NOTA  = 6'h06;
  localparam logic [5:0] OP_NOTB  = 6'h07;
  localparam logic [5:0] OP_SHL   = 6'h08;
  localparam logic [5:0] OP_SHR   = 6'h09;
  localparam logic [5:0] OP_SRA   = 6'h0A;
  localparam logic [5:0] OP_LUI   = 6'h0B;
  localparam logic [5:0] OP_ADD   = 6'h0C;
  localparam logic [5:0] OP_SUB   = 6'h0D;
  localparam logic [5:0] OP_LAST  = 6'h0D;

  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_N = 2;
  localparam int F_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes arrive zero-extended to 32 bits so any request width compares safely.
  function automatic logic op_legal(input logic [31:0] op);
    return op <= 32'(OP_LAST);
  endfunction

  // Only the arithmetic ops drive flags worth reporting; the rest are masked.
  function automatic logic op_has_flags(input logic [31:0] op);
    return (op == 32'(OP_ADD)) || (op == 32'(OP_SUB));
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator-side controller for the combinational ALU.
// Accepts one request at a time, drives the ALU with registered operands,
// waits SETTLE extra cycles, captures result/flags and returns them over a
// response handshake. Keeps OR-accumulated sticky flags for software.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_a, req_b, req_op, req_sign payload
//   rsp_valid/rsp_ready  response handshake; rsp_result, rsp_flags {V,N,Z,C}, rsp_illegal
//   alu_a, alu_b, alu_operation, alu_sign   registered drive into the ALU
//   alu_respuesta, alu_z, alu_n, alu_c, alu_v  ALU outputs
//   sticky_flags, sticky_clr                 accumulated {V,N,Z,C} and its clear
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OP_W   = 6,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  input  logic             req_sign,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [31:0]      alu_operation,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_respuesta,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [3:0]       sticky_flags,
  input  logic             sticky_clr
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      req_op_ext;
  logic             legal_acc;
  logic             illegal_acc;
  logic             capture;
  logic [3:0]       cap_flags;

  assign req_op_ext = 32'(req_op);

  // Flags are taken from the opcode actually driving the ALU, not the request port.
  always_comb begin
    cap_flags = '0;
    if (op_has_flags(alu_operation)) begin
      cap_flags[F_C] = alu_c;
      cap_flags[F_Z] = alu_z;
      cap_flags[F_N] = alu_n;
      cap_flags[F_V] = alu_v;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    legal_acc   = 1'b0;
    illegal_acc = 1'b0;
    capture     = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (op_legal(req_op_ext)) begin
            legal_acc = 1'b1;
            cnt_nxt   = CNT_W'(SETTLE);
            state_nxt = WAIT;
          end else begin
            // Illegal ops never reach the ALU; answer straight away.
            illegal_acc = 1'b1;
            state_nxt   = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ALU drive registers move only on a legal accept and hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
      alu_sign      <= 1'b0;
    end else if (legal_acc) begin
      alu_a         <= req_a;
      alu_b         <= req_b;
      alu_operation <= req_op_ext;
      alu_sign      <= req_sign;
    end
  end

  // Response payload is written only on entry to RESP, so it stays stable there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rsp_illegal  <= 1'b0;
      sticky_flags <= '0;
    end else begin
      if (illegal_acc) begin
        rsp_result  <= '0;
        rsp_flags   <= '0;
        rsp_illegal <= 1'b1;
      end else if (capture) begin
        rsp_result  <= alu_respuesta;
        rsp_flags   <= cap_flags;
        rsp_illegal <= 1'b0;
      end
      // A clear coinciding with a capture leaves exactly the captured flags.
      if (capture) begin
        sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags) | cap_flags;
      end else if (sticky_clr) begin
        sticky_flags <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        rst1_n, rst3_n;
  logic        req_valid, req_sign, rsp_ready, sticky_clr;
  logic [31:0] req_a, req_b;
  logic [5:0]  req_op;

  // DUT with SETTLE=1
  logic        req_ready, rsp_valid, rsp_illegal, alu_sign;
  logic [31:0] rsp_result, alu_a, alu_b, alu_operation, alu_respuesta;
  logic [3:0]  rsp_flags, sticky_flags;
  logic        alu_z, alu_n, alu_c, alu_v;
  logic [35:0] m1;

  // DUT with SETTLE=3
  logic        req_ready3, rsp_valid3, rsp_illegal3, alu_sign3;
  logic [31:0] rsp_result3, alu_a3, alu_b3, alu_operation3, alu_respuesta3;
  logic [3:0]  rsp_flags3, sticky_flags3;
  logic        alu_z3, alu_n3, alu_c3, alu_v3;
  logic [35:0] m3;

  int checks;
  int failures;

  // Behavioural ALU: returns {V,N,Z,C,result}. Signed ops report V, unsigned report C.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] op, input logic s);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      32'h00: r = a;
      32'h01: r = b;
      32'h02: r = a & b;
      32'h03: r = a | b;
      32'h04: r = a ^ b;
      32'h05: r = a ~^ b;
      32'h06: r = ~a;
      32'h07: r = ~b;
      32'h08: r = a << b[4:0];
      32'h09: r = a >> b[4:0];
      32'h0A: r = $unsigned($signed(a) >>> b[4:0]);
      32'h0B: r = {b[15:0], 16'h0000};
      32'h0C: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = s ? 1'b0 : w[32];
        v = s ? ((a[31] == b[31]) && (r[31] != a[31])) : 1'b0;
      end
      32'h0D: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = w[31:0];
        c = s ? 1'b0 : ~w[32];
        v = s ? ((a[31] != b[31]) && (r[31] != a[31])) : 1'b0;
      end
      default: r = '0;
    endcase
    return {v, r[31], (r == 32'h0), c, r};
  endfunction

  always_comb begin
    m1 = alu_model(alu_a, alu_b, alu_operation, alu_sign);
    m3 = alu_model(alu_a3, alu_b3, alu_operation3, alu_sign3);
  end
  assign alu_respuesta  = m1[31:0];
  assign {alu_v, alu_n, alu_z, alu_c} = m1[35:32];
  assign alu_respuesta3 = m3[31:0];
  assign {alu_v3, alu_n3, alu_z3, alu_c3} = m3[35:32];

  alu_issue_ctrl #(.WIDTH(32), .OP_W(6), .SETTLE(1)) dut (
    .clk(clk), .reset_n(rst1_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_sign(req_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .alu_sign(alu_sign),
    .alu_respuesta(alu_respuesta), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
  );

  alu_issue_ctrl #(.WIDTH(32), .OP_W(6), .SETTLE(3)) dut3 (
    .clk(clk), .reset_n(rst3_n),
    .req_valid(req_valid), .req_ready(req_ready3), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_sign(req_sign),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
    .rsp_flags(rsp_flags3), .rsp_illegal(rsp_illegal3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_operation(alu_operation3), .alu_sign(alu_sign3),
    .alu_respuesta(alu_respuesta3), .alu_z(alu_z3), .alu_n(alu_n3), .alu_c(alu_c3), .alu_v(alu_v3),
    .sticky_flags(sticky_flags3), .sticky_clr(sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for exactly one cycle; returns 1ns after the accepting edge.
  task automatic start_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] op, input logic s);
    @(posedge clk); #1;
    req_a = a; req_b = b; req_op = op; req_sign = s; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst1_n = 1'b0; rst3_n = 1'b0;
    #2;
    checks++;
    if ({rsp_valid, rsp_result, rsp_flags, rsp_illegal, alu_a, alu_b, alu_operation, alu_sign, sticky_flags} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b res=%h flags=%b ill=%b a=%h b=%h op=%h sticky=%b required all 0",
               rsp_valid, rsp_result, rsp_flags, rsp_illegal, alu_a, alu_b, alu_operation, sticky_flags);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready got=%b required=1", req_ready);
    end
    @(posedge clk); #3 rst1_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_idle got valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_overflow();
    start_req(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b1);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || alu_a !== 32'h7FFF_FFFF || alu_operation !== 32'h0C) begin
      failures++;
      $display("FAIL ovf_wait1 got valid=%b ready=%b a=%h op=%h required 0/0/7fffffff/0000000c",
               rsp_valid, req_ready, alu_a, alu_operation);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL ovf_wait2 rsp_valid got=%b required=0", rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h8000_0000 || rsp_flags !== 4'b1100 || rsp_illegal !== 1'b0) begin
      failures++;
      $display("FAIL ovf_rsp got valid=%b res=%h flags=%b ill=%b required 1/80000000/1100/0",
               rsp_valid, rsp_result, rsp_flags, rsp_illegal);
    end
    checks++;
    if (sticky_flags !== 4'b1100) begin
      failures++; $display("FAIL ovf_sticky got=%b required=1100", sticky_flags);
    end
    handshake();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL ovf_done got valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_logic_mask();
    int cyc;
    logic op_bad;
    start_req(32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 1'b0);
    cyc = 0; op_bad = 1'b0;
    while (!rsp_valid && cyc < 10) begin
      if (alu_operation !== 32'h0000_0002) op_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 2) begin
      failures++; $display("FAIL and_latency got=%0d required=2", cyc);
    end
    checks++;
    if (op_bad !== 1'b0 || alu_operation !== 32'h0000_0002) begin
      failures++; $display("FAIL and_op_stable got=%h required=00000002", alu_operation);
    end
    checks++;
    if (rsp_result !== 32'hF000_F000 || rsp_flags !== 4'b0000 || sticky_flags !== 4'b1100) begin
      failures++;
      $display("FAIL and_rsp got res=%h flags=%b sticky=%b required f000f000/0000/1100",
               rsp_result, rsp_flags, sticky_flags);
    end
    handshake();
  endtask

  task automatic test_illegal();
    start_req(32'hAAAA_AAAA, 32'hBBBB_BBBB, 6'h20, 1'b1);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_result !== 32'h0 || rsp_flags !== 4'b0000) begin
      failures++;
      $display("FAIL illegal_rsp got valid=%b ill=%b res=%h flags=%b required 1/1/00000000/0000",
               rsp_valid, rsp_illegal, rsp_result, rsp_flags);
    end
    checks++;
    if (alu_a !== 32'hF0F0_F0F0 || alu_b !== 32'hFF00_FF00 || alu_operation !== 32'h2 || alu_sign !== 1'b0) begin
      failures++;
      $display("FAIL illegal_alu_hold got a=%h b=%h op=%h s=%b required f0f0f0f0/ff00ff00/00000002/0",
               alu_a, alu_b, alu_operation, alu_sign);
    end
    checks++;
    if (sticky_flags !== 4'b1100) begin
      failures++; $display("FAIL illegal_sticky got=%b required=1100", sticky_flags);
    end
    handshake();
  endtask

  task automatic test_sticky_collision();
    start_req(32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (sticky_flags !== 4'b1100) begin
      failures++; $display("FAIL coll_pre_sticky got=%b required=1100", sticky_flags);
    end
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_flags !== 4'b0011) begin
      failures++;
      $display("FAIL coll_rsp got valid=%b res=%h flags=%b required 1/00000000/0011",
               rsp_valid, rsp_result, rsp_flags);
    end
    checks++;
    if (sticky_flags !== 4'b0011) begin
      failures++; $display("FAIL coll_sticky got=%b required=0011", sticky_flags);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int cyc;
    start_req(32'h5, 32'h5, OP_SUB, 1'b1);
    cyc = 0;
    while (!rsp_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 2) begin
      failures++; $display("FAIL bp_latency got=%0d required=2", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_a = 32'h99; req_b = 32'h1; req_op = OP_ADD; req_sign = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_flags !== 4'b0010 ||
          req_ready !== 1'b0 || alu_a !== 32'h5) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%b res=%h flags=%b ready=%b a=%h required 1/00000000/0010/0/00000005",
                 i, rsp_valid, rsp_result, rsp_flags, req_ready, alu_a);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    handshake();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_a !== 32'h5 || sticky_flags !== 4'b0011) begin
      failures++;
      $display("FAIL bp_done got valid=%b ready=%b a=%h sticky=%b required 0/1/00000005/0011",
               rsp_valid, req_ready, alu_a, sticky_flags);
    end
  endtask

  task automatic test_sticky_clr();
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    checks++;
    if (sticky_flags !== 4'b0000) begin
      failures++; $display("FAIL sticky_clr got=%b required=0000", sticky_flags);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    logic seen;
    rst3_n = 1'b1;
    rsp_ready = 1'b1;  // keep the SETTLE=1 instance cycling; it shares the request bus
    start_req(32'h11, 32'h22, OP_ADD, 1'b0);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid3 !== 1'b0 || alu_operation3 !== 32'h0C || alu_a3 !== 32'h11) begin
      failures++;
      $display("FAIL mid_wait_drive got valid=%b op=%h a=%h required 0/0000000c/00000011",
               rsp_valid3, alu_operation3, alu_a3);
    end
    @(posedge clk); #2;
    rst3_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid3, rsp_result3, rsp_flags3, rsp_illegal3, alu_a3, alu_b3, alu_operation3, alu_sign3, sticky_flags3} !== '0 ||
        req_ready3 !== 1'b1) begin
      failures++;
      $display("FAIL mid_wait_reset got valid=%b a=%h b=%h op=%h ready=%b required 0/0/0/0/1",
               rsp_valid3, alu_a3, alu_b3, alu_operation3, req_ready3);
    end
    #3 rst3_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid3 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL mid_wait_no_rsp got rsp_valid seen=%b required=0", seen);
    end
    rsp_ready = 1'b1;
    // Let the SETTLE=1 instance drain back to IDLE before the next shared request.
    repeat (4) @(posedge clk);
    #1 rsp_ready = 1'b0;
    start_req(32'h3, 32'h4, OP_ADD, 1'b0);
    cyc = 0;
    while (!rsp_valid3 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 4) begin
      failures++; $display("FAIL s3_latency got=%0d required=4", cyc);
    end
    checks++;
    if (rsp_result3 !== 32'h7 || rsp_flags3 !== 4'b0000 || rsp_illegal3 !== 1'b0 || sticky_flags3 !== 4'b0000) begin
      failures++;
      $display("FAIL s3_rsp got res=%h flags=%b ill=%b sticky=%b required 00000007/0000/0/0000",
               rsp_result3, rsp_flags3, rsp_illegal3, sticky_flags3);
    end
    handshake();
    checks++;
    if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin
      failures++; $display("FAIL s3_done got valid=%b ready=%b required 0/1", rsp_valid3, req_ready3);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst1_n = 1'b1; rst3_n = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_sign = 1'b0;
    rsp_ready = 1'b0; sticky_clr = 1'b0;
    test_reset();
    test_overflow();
    test_logic_mask();
    test_illegal();
    test_sticky_collision();
    test_backpressure();
    test_sticky_clr();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator-side controller for the team's combinational ALU.
- Accepts operation requests over a valid/ready handshake, decodes and validates the 6-bit opcode, and drives the ALU operand, opcode and sign inputs as registered, stable values.
- Waits a programmable settle time, then captures the ALU result and the Z/N/C/V flags. Returns them over a response handshake and keeps sticky flag status for software.

Parameters:
- WIDTH, 32, operand/result width.
- OP_W, 6, request opcode width; zero-extended to 32 bits on alu_operation.
- SETTLE, 1, extra wait cycles between driving the ALU and capturing its outputs (0 allowed).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_op  in  OP_W  opcode.
- req_sign  in  1  1 = signed add/sub.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_flags  out  4  {V,N,Z,C} as captured.
- rsp_illegal  out  1  opcode was out of range.
- alu_a  out  WIDTH  drives ALU A.
- alu_b  out  WIDTH  drives ALU B.
- alu_operation  out  32  drives ALU operation (zero-extended opcode).
- alu_sign  out  1  drives ALU sign.
- alu_respuesta  in  WIDTH  ALU result.
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags.
- sticky_flags  out  4  OR-accumulated {V,N,Z,C}.
- sticky_clr  in  1  clears sticky_flags.

Interface decision: single clock clk; reset_n is asynchronous, active-low.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE. Every output is 0, except req_ready, which is 1 once in IDLE. A reset mid-operation aborts the operation and the pending response is lost.
- Legal opcodes: 0x00–0x0D (PASS A, PASS B, AND, OR, XOR, XNOR, NOT A, NOT B, SHL, SHR, SRA, LUI, ADD, SUB). Any opcode ≥ 0x0E is illegal.
- IDLE: req_ready=1.
  - Legal accept (req_valid&&req_ready) at edge k: register alu_a/alu_b/alu_operation/alu_sign from the request, load cnt=SETTLE, go to WAIT.
  - Illegal accept: ALU outputs unchanged; rsp_result=0, rsp_flags=0, rsp_illegal=1; go to RESP.
- WAIT: req_ready=0.
  - If cnt==0: capture alu_respuesta into rsp_result, capture flags, rsp_illegal=0, go to RESP.
  - Otherwise decrement cnt.
  - Capture happens at edge k+SETTLE+1; rsp_valid is high in the following cycle.
- Flag masking: flags are captured only for 0x0C/0x0D. For all other legal opcodes, rsp_flags=0.
- RESP: rsp_valid=1 and rsp_* held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE. There is no same-cycle re-accept; req_ready rises the next cycle.
- Throughput: one operation per SETTLE+3 cycles with rsp_ready tied high.
- ALU drive registers change only on a legal accept. They are held through WAIT, RESP and IDLE.
- Sticky flags: on each capture, sticky_flags |= captured masked flags.
  - sticky_clr alone: clears to 0.
  - sticky_clr in the same cycle as a capture: sticky_flags = captured flags.
  - Illegal responses do not touch sticky_flags.
- rsp_valid never rises without a preceding accept. req_valid is ignored outside IDLE.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_PASSA=6'h00 … OP_ADD=6'h0C, OP_SUB=6'h0D, OP_LAST=6'h0D;
  - flag bit indices F_C=0, F_Z=1, F_N=2, F_V=3;
  - state encoding IDLE/WAIT/RESP.
- No sub-module: one FSM with a settle counter. The bench instantiates the ALU (or a behavioural stub) on the alu_* side.

Test Plan:
- Signed overflow: after reset, req ADD a=0x7FFFFFFF b=0x1 sign=1, SETTLE=1 → rsp_valid 2 cycles after accept; rsp_result=0x80000000; rsp_flags V=1, N=1; sticky_flags V and N set.
- Logic op masking: req AND a=0xF0F0F0F0 b=0xFF00FF00 → rsp_result=0xF000F000, rsp_flags=0, alu_operation=0x00000002 stable throughout WAIT.
- Illegal opcode: req_op=0x20 → rsp_valid one cycle after accept, rsp_illegal=1, result 0; alu_* unchanged; sticky_flags unchanged.
- Backpressure: SUB signed a=5 b=5 with rsp_ready low for 4 cycles → rsp_result=0, Z=1 held stable; req_ready=0 and a second req_valid ignored until the handshake completes.
- Sticky clear collision: sticky_flags=4'b1100, then sticky_clr asserted in the capture cycle of an unsigned ADD 0xFFFFFFFF+1 giving C=1 → sticky_flags=the captured flags exactly.
- Reset mid-WAIT (SETTLE=3), reset_n pulsed low asynchronously → all outputs 0 immediately; no rsp_valid afterwards; next request completes normally.
